rgmii_rx_adapter: RTL and testbench

Receive-side adapter between the RGMII PHY interface's GMII outputs and the MAC receive path, clocked by the recovered RX clock. At 10/100 Mb/s it assembles the one-nibble-per-clock stream into bytes aligned on the SFD and produces a byte-rate clock enable. At 1000 Mb/s it passes bytes straight through. In all modes it decodes and filters RGMII in-band link status sampled between frames.

---
 rtl/eth_rgmii_pkg.sv | 40 ++++
 rtl/rgmii_inband_status_filter.sv | 77 +++++++
 rtl/rgmii_rx_adapter.sv | 198 +++++++++++++++++++
 tb/tb_rgmii_rx_adapter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rgmii_pkg.sv
// -----------------------------------------------------------------------------
// eth_rgmii_pkg
// Shared constants and types for the RGMII receive adapter: speed encodings,
// preamble/SFD nibble values, the nibble-assembly state enum and the in-band
// status payload layout.
// -----------------------------------------------------------------------------
package eth_rgmii_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned SPEED_W = 2;

    localparam logic [SPEED_W-1:0] SPEED_10   = 2'b00;
    localparam logic [SPEED_W-1:0] SPEED_100  = 2'b01;
    localparam logic [SPEED_W-1:0] SPEED_1000 = 2'b10;

    localparam logic [NIB_W-1:0] NIB_PRE = 4'h5;
    localparam logic [NIB_W-1:0] NIB_SFD = 4'hD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_LOW,
        ST_HIGH,
        ST_DROP
    } rx_state_e;

    // Bit order matches gmii_rxd[3:0] while idle: {duplex, speed[1:0], link}.
    typedef struct packed {
        logic       full_duplex;
        logic [1:0] speed;
        logic       link;
    } inband_status_t;

    // 2'b11 is reserved and treated as gigabit.
    function automatic logic is_gig(input logic [SPEED_W-1:0] spd);
        return (spd != SPEED_10) && (spd != SPEED_100);
    endfunction

endpackage

// File: rtl/rgmii_inband_status_filter.sv
// -----------------------------------------------------------------------------
// rgmii_inband_status_filter
// Debounces the RGMII in-band status carried on rxd[3:0] between frames.
// A status value must be seen STATUS_FILTER times in a row (with no frame or
// error cycle in between) before it is published.
//   clk, rst       : clock, synchronous active-high reset
//   sample_valid   : rxd[3:0] currently carries in-band status
//   sample         : raw in-band status nibble
//   link_up, link_speed, full_duplex : filtered status
//   status_change  : one-cycle pulse when the filtered status changes
// -----------------------------------------------------------------------------
module rgmii_inband_status_filter
    import eth_rgmii_pkg::*;
#(
    parameter int unsigned STATUS_FILTER = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_valid,
    input  inband_status_t       sample,
    output logic                 link_up,
    output logic [SPEED_W-1:0]   link_speed,
    output logic                 full_duplex,
    output logic                 status_change
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] FILT = CNT_W'(STATUS_FILTER);

    inband_status_t   cand_q, cand_d;
    inband_status_t   stat_q, stat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             change_q, change_d;

    // Candidate/counter update and publish decision.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stat_d   = stat_q;
        change_d = 1'b0;

        if (!sample_valid) begin
            cnt_d = '0;
        end else if (sample != cand_q) begin
            cand_d = sample;
            cnt_d  = CNT_W'(1);
        end else if (cnt_q < FILT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // cnt_d is zero on invalid cycles, so this only fires on a valid sample.
        if ((cnt_d == FILT) && (cand_d != stat_q)) begin
            stat_d   = cand_d;
            change_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q   <= '0;
            stat_q   <= '0;
            cnt_q    <= '0;
            change_q <= 1'b0;
        end else begin
            cand_q   <= cand_d;
            stat_q   <= stat_d;
            cnt_q    <= cnt_d;
            change_q <= change_d;
        end
    end

    assign link_up       = stat_q.link;
    assign link_speed    = stat_q.speed;
    assign full_duplex   = stat_q.full_duplex;
    assign status_change = change_q;

endmodule

// File: rtl/rgmii_rx_adapter.sv
// -----------------------------------------------------------------------------
// rgmii_rx_adapter
// Receive-side adapter from the RGMII PHY block's GMII outputs to the MAC.
// 1000M: registered pass-through with a constant clock enable.
// 10/100: nibble-to-byte assembly aligned on the SFD; out_gmii_rx_clk_en marks
// the cycles on which the out_* bus carries a beat.
// In-band link status is filtered in all modes.
//   clk, rst                  : RX clock, synchronous active-high reset
//   gmii_rxd/_rx_dv/_rx_er    : GMII receive bus from the PHY interface
//   speed                     : configured speed (latched between frames)
//   out_gmii_rxd/_rx_dv/_rx_er: byte-wide receive bus to the MAC
//   out_gmii_rx_clk_en        : qualifies out_gmii_*
//   link_up/link_speed/full_duplex/status_change : filtered in-band status
//   align_err                 : pulse on a preamble error or odd-nibble end
// -----------------------------------------------------------------------------
module rgmii_rx_adapter
    import eth_rgmii_pkg::*;
#(
    parameter int unsigned STATUS_FILTER = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BYTE_W-1:0]   gmii_rxd,
    input  logic                gmii_rx_dv,
    input  logic                gmii_rx_er,
    input  logic [SPEED_W-1:0]  speed,
    output logic [BYTE_W-1:0]   out_gmii_rxd,
    output logic                out_gmii_rx_dv,
    output logic                out_gmii_rx_er,
    output logic                out_gmii_rx_clk_en,
    output logic                link_up,
    output logic [SPEED_W-1:0]  link_speed,
    output logic                full_duplex,
    output logic                status_change,
    output logic                align_err
);

    rx_state_e          state_q;
    logic [SPEED_W-1:0] speed_q;
    logic               phase_q;
    logic [NIB_W-1:0]   prev_nib_q;
    logic [NIB_W-1:0]   low_nib_q;
    logic               er_acc_q;
    logic [BYTE_W-1:0]  rxd_q;
    logic               dv_q;
    logic               er_q;
    logic               clk_en_q;
    logic               align_err_q;

    logic [NIB_W-1:0]   nib;
    logic               gig;
    logic               status_valid;
    inband_status_t     status_sample;

    assign nib           = gmii_rxd[NIB_W-1:0];
    assign gig           = is_gig(speed_q);
    assign status_valid  = !gmii_rx_dv && !gmii_rx_er;
    assign status_sample = gmii_rxd[NIB_W-1:0];

    // Datapath and nibble-assembly FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            speed_q     <= SPEED_10;
            phase_q     <= 1'b0;
            prev_nib_q  <= '0;
            low_nib_q   <= '0;
            er_acc_q    <= 1'b0;
            rxd_q       <= '0;
            dv_q        <= 1'b0;
            er_q        <= 1'b0;
            clk_en_q    <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= 1'b0;
            prev_nib_q  <= nib;

            // Speed only moves between frames so a frame is never split across modes.
            if (state_q == ST_IDLE) begin
                speed_q <= speed;
            end

            if (gig) begin
                state_q  <= ST_IDLE;
                rxd_q    <= gmii_rxd;
                dv_q     <= gmii_rx_dv;
                er_q     <= gmii_rx_er;
                clk_en_q <= 1'b1;
            end else begin
                clk_en_q <= 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        // Idle beats keep the byte-rate enable running at half the clock.
                        clk_en_q <= ~clk_en_q;
                        rxd_q    <= '0;
                        dv_q     <= 1'b0;
                        er_q     <= 1'b0;
                        er_acc_q <= 1'b0;
                        if (gmii_rx_dv) begin
                            state_q <= ST_PRE;
                            phase_q <= 1'b0;
                        end
                    end

                    ST_PRE: begin
                        if (!gmii_rx_dv) begin
                            state_q <= ST_IDLE;
                        end else if ((nib == NIB_SFD) && (prev_nib_q == NIB_PRE)) begin
                            // SFD wins over a coincident preamble emission point.
                            clk_en_q <= 1'b1;
                            rxd_q    <= {NIB_SFD, NIB_PRE};
                            dv_q     <= 1'b1;
                            er_q     <= gmii_rx_er;
                            state_q  <= ST_LOW;
                        end else if (nib == NIB_PRE) begin
                            phase_q <= ~phase_q;
                            if (phase_q) begin
                                clk_en_q <= 1'b1;
                                rxd_q    <= {NIB_PRE, NIB_PRE};
                                dv_q     <= 1'b1;
                                er_q     <= gmii_rx_er;
                            end
                        end else begin
                            align_err_q <= 1'b1;
                            state_q     <= ST_DROP;
                        end
                    end

                    ST_LOW: begin
                        if (!gmii_rx_dv) begin
                            clk_en_q <= 1'b1;
                            rxd_q    <= '0;
                            dv_q     <= 1'b0;
                            er_q     <= 1'b0;
                            state_q  <= ST_IDLE;
                        end else begin
                            low_nib_q <= nib;
                            er_acc_q  <= er_acc_q | gmii_rx_er;
                            state_q   <= ST_HIGH;
                        end
                    end

                    ST_HIGH: begin
                        er_acc_q <= 1'b0;
                        clk_en_q <= 1'b1;
                        if (!gmii_rx_dv) begin
                            // Odd nibble count: the stored low nibble is discarded.
                            align_err_q <= 1'b1;
                            rxd_q       <= '0;
                            dv_q        <= 1'b0;
                            er_q        <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else begin
                            rxd_q   <= {nib, low_nib_q};
                            dv_q    <= 1'b1;
                            er_q    <= er_acc_q | gmii_rx_er;
                            state_q <= ST_LOW;
                        end
                    end

                    ST_DROP: begin
                        if (!gmii_rx_dv) begin
                            clk_en_q <= 1'b1;
                            rxd_q    <= '0;
                            dv_q     <= 1'b0;
                            er_q     <= 1'b0;
                            state_q  <= ST_IDLE;
                        end
                    end

                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    rgmii_inband_status_filter #(
        .STATUS_FILTER (STATUS_FILTER)
    ) u_status (
        .clk           (clk),
        .rst           (rst),
        .sample_valid  (status_valid),
        .sample        (status_sample),
        .link_up       (link_up),
        .link_speed    (link_speed),
        .full_duplex   (full_duplex),
        .status_change (status_change)
    );

    assign out_gmii_rxd       = rxd_q;
    assign out_gmii_rx_dv     = dv_q;
    assign out_gmii_rx_er     = er_q;
    assign out_gmii_rx_clk_en = clk_en_q;
    assign align_err          = align_err_q;

endmodule

// File: tb/tb_rgmii_rx_adapter.sv
// -----------------------------------------------------------------------------
// tb_rgmii_rx_adapter
// Directed and randomized bench for rgmii_rx_adapter. Expected bytes come from
// a frame-level decoder of the nibble list; expected status from a run-length
// model of idle samples.
// -----------------------------------------------------------------------------
module tb_rgmii_rx_adapter;
    import eth_rgmii_pkg::*;

    localparam int FILT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;
    logic [1:0] speed;
    logic [7:0] out_gmii_rxd;
    logic       out_gmii_rx_dv;
    logic       out_gmii_rx_er;
    logic       out_gmii_rx_clk_en;
    logic       link_up;
    logic [1:0] link_speed;
    logic       full_duplex;
    logic       status_change;
    logic       align_err;

    rgmii_rx_adapter #(.STATUS_FILTER(FILT)) dut (
        .clk                (clk),
        .rst                (rst),
        .gmii_rxd           (gmii_rxd),
        .gmii_rx_dv         (gmii_rx_dv),
        .gmii_rx_er         (gmii_rx_er),
        .speed              (speed),
        .out_gmii_rxd       (out_gmii_rxd),
        .out_gmii_rx_dv     (out_gmii_rx_dv),
        .out_gmii_rx_er     (out_gmii_rx_er),
        .out_gmii_rx_clk_en (out_gmii_rx_clk_en),
        .link_up            (link_up),
        .link_speed         (link_speed),
        .full_duplex        (full_duplex),
        .status_change      (status_change),
        .align_err          (align_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Status model: length of the current run of identical valid samples.
    logic [3:0] m_run_val;
    int         m_run_len;
    logic [3:0] m_stat;
    logic       m_chg;
    int         chg_cnt;

    bit         chk_gig;
    bit         capturing;
    logic [8:0] cap_q[$];
    int         ali_cnt;
    logic [3:0] fr_nib[$];
    logic       fr_er[$];
    logic [8:0] exp_q[$];
    int         exp_ali;
    logic [7:0] idle_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_status(input logic r, input logic [3:0] s, input logic dv, input logic er);
        m_chg = 1'b0;
        if (r) begin
            m_run_len = 0;
            m_run_val = '0;
            m_stat    = '0;
        end else if (dv || er) begin
            m_run_len = 0;
        end else begin
            if (m_run_len > 0 && s == m_run_val) m_run_len++;
            else begin
                m_run_val = s;
                m_run_len = 1;
            end
            if (m_run_len >= FILT && m_run_val != m_stat) begin
                m_stat = m_run_val;
                m_chg  = 1'b1;
            end
        end
    endtask

    // One clock: drive, clock, observe #1 after the edge.
    task automatic step(input logic [7:0] d, input logic dv, input logic er);
        gmii_rxd   = d;
        gmii_rx_dv = dv;
        gmii_rx_er = er;
        @(posedge clk);
        #1;
        model_status(rst, d[3:0], dv, er);
        if (status_change) chg_cnt++;
        chk("status", 32'({full_duplex, link_speed, link_up, status_change}), 32'({m_stat, m_chg}));
        if (chk_gig)
            chk("gig_pass", 32'({out_gmii_rx_clk_en, out_gmii_rx_dv, out_gmii_rx_er, out_gmii_rxd}),
                32'({1'b1, dv, er, d}));
        if (capturing) begin
            if (out_gmii_rx_clk_en && out_gmii_rx_dv) cap_q.push_back({out_gmii_rx_er, out_gmii_rxd});
            if (align_err) ali_cnt++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(idle_val, 1'b0, 1'b0);
    endtask

    // In 10/100 idle the enable must alternate every cycle with dv low.
    task automatic idle_tog(input string tag);
        logic [5:0] p;
        logic       anydv;
        p = '0;
        anydv = 1'b0;
        idle(2);
        for (int k = 0; k < 6; k++) begin
            step(idle_val, 1'b0, 1'b0);
            p[k]  = out_gmii_rx_clk_en;
            anydv = anydv | out_gmii_rx_dv;
        end
        chk(tag, 32'((p == 6'b101010 || p == 6'b010101) && !anydv), 32'(1));
    endtask

    task automatic make_frame(input int n_pre, input int n_data, input int er_idx);
        fr_nib.delete();
        fr_er.delete();
        repeat (n_pre) begin
            fr_nib.push_back(NIB_PRE);
            fr_er.push_back(1'b0);
        end
        fr_nib.push_back(NIB_SFD);
        fr_er.push_back(1'b0);
        for (int k = 0; k < n_data; k++) begin
            fr_nib.push_back(4'($urandom_range(15)));
            fr_er.push_back(k == er_idx);
        end
    endtask

    // Frame-level decode: the first nibble is lost while the adapter notices dv,
    // every second 5 afterwards is a 0x55 byte, 5-then-D is the SFD, then pairs
    // of nibbles form bytes low-first; any other preamble nibble or a leftover
    // nibble is an alignment error.
    task automatic build_exp();
        int  i;
        int  fives;
        bit  sfd;
        exp_q.delete();
        exp_ali = 0;
        i       = 1;
        fives   = 0;
        sfd     = 1'b0;
        while (i < fr_nib.size() && !sfd && exp_ali == 0) begin
            if (fr_nib[i] == NIB_SFD && fr_nib[i-1] == NIB_PRE) begin
                exp_q.push_back({1'b0, 8'hD5});
                sfd = 1'b1;
            end else if (fr_nib[i] == NIB_PRE) begin
                fives++;
                if (fives % 2 == 0) exp_q.push_back({1'b0, 8'h55});
            end else begin
                exp_ali = 1;
            end
            i++;
        end
        if (sfd) begin
            while (i + 1 < fr_nib.size()) begin
                exp_q.push_back({fr_er[i] | fr_er[i+1], fr_nib[i+1], fr_nib[i]});
                i += 2;
            end
            if (i < fr_nib.size()) exp_ali = 1;
        end
    endtask

    task automatic run_frame(input string tag, input int spd_at, input logic [1:0] spd_new);
        build_exp();
        cap_q.delete();
        ali_cnt   = 0;
        capturing = 1'b1;
        foreach (fr_nib[i]) begin
            if (i == spd_at) speed = spd_new;
            step({4'($urandom_range(15)), fr_nib[i]}, 1'b1, fr_er[i]);
        end
        step(idle_val, 1'b0, 1'b0);
        chk({tag, "_end_beat"}, 32'({out_gmii_rx_clk_en, out_gmii_rx_dv, out_gmii_rx_er}), 32'(3'b100));
        step(idle_val, 1'b0, 1'b0);
        capturing = 1'b0;
        chk({tag, "_nbytes"}, cap_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++)
            chk({tag, "_byte"}, 32'(cap_q[k]), 32'(exp_q[k]));
        chk({tag, "_align"}, ali_cnt, exp_ali);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        gmii_rxd   = '0;
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b0;
        speed      = SPEED_100;
        idle_val   = 8'h00;
        chk_gig    = 1'b0;
        capturing  = 1'b0;
        chg_cnt    = 0;
        m_run_val  = '0;
        m_run_len  = 0;
        m_stat     = '0;
        m_chg      = 1'b0;

        // Reset values.
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        chk("reset_out", 32'({out_gmii_rxd, out_gmii_rx_dv, out_gmii_rx_er, out_gmii_rx_clk_en,
                              link_up, link_speed, full_duplex, status_change, align_err}), 32'(0));
        rst = 1'b0;

        // 100M assembly of the reference frame.
        idle(3);
        idle_tog("idle100_toggle");
        make_frame(15, 0, -1);
        fr_nib.push_back(4'h1); fr_er.push_back(1'b0);
        fr_nib.push_back(4'h0); fr_er.push_back(1'b0);
        fr_nib.push_back(4'h2); fr_er.push_back(1'b0);
        fr_nib.push_back(4'h0); fr_er.push_back(1'b0);
        run_frame("f100", -1, SPEED_100);
        if (cap_q.size() == 10) begin
            chk("f100_first", 32'(cap_q[0]), 32'(9'h055));
            chk("f100_sfd",   32'(cap_q[7]), 32'(9'h0D5));
            chk("f100_b0",    32'(cap_q[8]), 32'(9'h001));
            chk("f100_b1",    32'(cap_q[9]), 32'(9'h002));
        end
        chk("f100_no_align", ali_cnt, 0);

        // In-band status filtering.
        idle(2);
        chg_cnt = 0;
        repeat (3) step(8'h0D, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        chk("st_no_update", 32'({full_duplex, link_speed, link_up}), 32'(0));
        repeat (4) step(8'h0D, 1'b0, 1'b0);
        chk("st_update", 32'({full_duplex, link_speed, link_up}), 32'(4'b1101));
        idle_val = 8'h0D;
        idle(4);
        chk("st_one_pulse", chg_cnt, 1);

        // 10M: odd nibble count with an error on a data nibble, then bad preamble.
        speed = SPEED_10;
        idle(3);
        make_frame(15, 5, 2);
        run_frame("odd_er", -1, SPEED_10);
        if (cap_q.size() == 10) chk("odd_er_flag", 32'(cap_q[9][8]), 32'(1));
        idle(2);
        fr_nib = '{4'h5, 4'h5, 4'h3, 4'h5, 4'h5, 4'h5, 4'hD, 4'h1, 4'h2};
        fr_er  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        run_frame("bad_pre", -1, SPEED_10);
        chk("bad_pre_nodv", cap_q.size(), 0);
        idle_tog("idle10_toggle");

        // 1000M pass-through.
        speed = SPEED_1000;
        idle(3);
        chk_gig = 1'b1;
        repeat (7) step(8'h55, 1'b1, 1'b0);
        step(8'hD5, 1'b1, 1'b0);
        step(8'h01, 1'b1, 1'b0);
        step(8'h02, 1'b1, 1'b0);
        repeat (20) step(8'($urandom_range(255)), 1'b1, ($urandom_range(7) == 0));
        idle(3);
        repeat (12) step(8'($urandom_range(255)), 1'b0, 1'b0);
        chk_gig = 1'b0;
        speed   = SPEED_100;
        idle_val = 8'h0D;
        idle(3);

        // Randomized 10/100 frames with random idle status.
        for (int r = 0; r < 10; r++) begin
            int n_pre;
            int n_data;
            speed = ($urandom_range(1) == 0) ? SPEED_10 : SPEED_100;
            case ($urandom_range(3))
                0:       idle_val = 8'h0D;
                1:       idle_val = 8'h0B;
                2:       idle_val = 8'h09;
                default: idle_val = 8'h00;
            endcase
            idle(4 + $urandom_range(6));
            n_pre  = 3 + $urandom_range(12);
            n_data = $urandom_range(16);
            make_frame(n_pre, n_data, (n_data > 0) ? $urandom_range(n_data) : -1);
            if ($urandom_range(3) == 0) fr_nib[1 + $urandom_range(n_pre - 2)] = 4'($urandom_range(15));
            run_frame("rand", -1, speed);
        end

        // Speed change mid-frame: assembly finishes, gigabit afterwards.
        speed    = SPEED_100;
        idle_val = 8'h0D;
        idle(4);
        make_frame(15, 8, -1);
        run_frame("spd_chg", 20, SPEED_1000);
        chk_gig = 1'b1;
        idle(3);
        repeat (6) step(8'($urandom_range(255)), 1'b1, 1'b0);
        idle(2);
        chk_gig = 1'b0;

        // Reset in the middle of a 100M frame.
        speed = SPEED_100;
        idle(4);
        make_frame(15, 10, -1);
        for (int k = 0; k < 20; k++) step({4'h0, fr_nib[k]}, 1'b1, 1'b0);
        rst = 1'b1;
        step({4'h0, fr_nib[20]}, 1'b1, 1'b0);
        chk("rst_mid", 32'({out_gmii_rxd, out_gmii_rx_dv, out_gmii_rx_er, out_gmii_rx_clk_en,
                            link_up, link_speed, full_duplex, status_change, align_err}), 32'(0));
        rst = 1'b0;
        idle(5);
        make_frame(9, 6, 3);
        run_frame("post_rst", -1, SPEED_100);
        idle(6);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
